// File: rtl/rd_burst_collector.sv
// rtl/rd_burst_collector.sv - collects per-edge read beats into a burst line and hands it off with valid/ready
// Optional stall timeout: define RD_BURST_TIMEOUT_EN.
module rd_burst_collector #(
  parameter int BURST   = 8,
  parameter int WORD_W  = 32,
  parameter int COL_W   = 3,
  parameter int TIMEOUT = 32
) (
  input  logic                    CLKx2,
  input  logic                    nRST,
  input  logic                    start,
  input  logic [COL_W-1:0]        col_choice,
  input  logic                    rd_en,
  input  logic                    clear,
  input  logic                    edge_flag,
  input  logic [WORD_W-1:0]       memload,
  output logic [BURST*WORD_W-1:0] line_data,
  output logic [WORD_W-1:0]       word_data,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic                    busy,
  output logic [COL_W:0]          beat_cnt,
  output logic                    err_overrun,
  output logic                    err_extra,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {IDLE, CAPTURE, VALID} state_t;

  localparam logic [COL_W:0] LAST_BEAT = (COL_W+1)'(BURST-1);
  localparam logic [COL_W:0] ONE       = (COL_W+1)'(1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic             beat;
  logic             last_beat;

  assign beat      = edge_flag && rd_en;
  assign last_beat = beat && (beat_cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

`ifdef RD_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT+1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT-1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge CLKx2 or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      col         <= '0;
      line_data   <= '0;
      word_data   <= '0;
      line_valid  <= 1'b0;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
      err_extra   <= 1'b0;
`ifdef RD_BURST_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
`endif
    end else if (clear) begin
      state       <= IDLE;
      line_valid  <= 1'b0;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
      err_extra   <= 1'b0;
`ifdef RD_BURST_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
`ifdef RD_BURST_TIMEOUT_EN
      // Counter only runs while in CAPTURE, so every entry starts from zero.
      if (state != CAPTURE) tmo_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPTURE;
            col      <= col_choice;
            beat_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (start) err_overrun <= 1'b1;
          if (beat) begin
            line_data[beat_cnt[COL_W-1:0]*WORD_W +: WORD_W] <= memload;
            if (beat_cnt[COL_W-1:0] == col) word_data <= memload;
            beat_cnt <= beat_cnt + ONE;
            if (last_beat) begin
              state      <= VALID;
              line_valid <= 1'b1;
            end
          end
`ifdef RD_BURST_TIMEOUT_EN
          if (!last_beat) begin
            if (tmo_cnt == TMO_LAST) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
              beat_cnt    <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`endif
        end
        VALID: begin
          if (beat) err_extra <= 1'b1;
          if (line_valid && line_ready) begin
            line_valid <= 1'b0;
            beat_cnt   <= '0;
            // A new request coinciding with the handoff chains straight into the next burst.
            if (start) begin
              state <= CAPTURE;
              col   <= col_choice;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            err_overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_burst_collector.sv
// tb/tb_rd_burst_collector.sv - directed self-checking bench for rd_burst_collector
module tb_rd_burst_collector;

  logic         CLKx2 = 1'b0;
  logic         nRST = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   col_choice = '0;
  logic         rd_en = 1'b0;
  logic         clear = 1'b0;
  logic         edge_flag = 1'b0;
  logic [31:0]  memload = '0;
  logic [255:0] line_data;
  logic [31:0]  word_data;
  logic         line_valid;
  logic         line_ready = 1'b0;
  logic         busy;
  logic [3:0]   beat_cnt;
  logic         err_overrun;
  logic         err_extra;
  logic         err_timeout;

  int total = 0;
  int bad = 0;
  logic [255:0] exp_line;
  logic [255:0] held_line;

  rd_burst_collector dut (
    .CLKx2(CLKx2), .nRST(nRST), .start(start), .col_choice(col_choice),
    .rd_en(rd_en), .clear(clear), .edge_flag(edge_flag), .memload(memload),
    .line_data(line_data), .word_data(word_data), .line_valid(line_valid),
    .line_ready(line_ready), .busy(busy), .beat_cnt(beat_cnt),
    .err_overrun(err_overrun), .err_extra(err_extra), .err_timeout(err_timeout)
  );

  always #5 CLKx2 = ~CLKx2;

  task automatic tick();
    @(posedge CLKx2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_beat(input logic [31:0] d);
    edge_flag = 1'b1; rd_en = 1'b1; memload = d;
    tick();
    edge_flag = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] c);
    start = 1'b1; col_choice = c;
    tick();
    start = 1'b0;
  endtask

  task automatic accept();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
  endtask

  initial begin
    // Reset
    #2 nRST = 1'b0;
    tick(); tick();
    chk("rst_line", line_data, '0);
    chk("rst_word", word_data, '0);
    chk("rst_valid", line_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_errs", {err_overrun, err_extra, err_timeout}, 0);
    nRST = 1'b1;
    tick();

    // Basic burst, col 5
    do_start(3'd5);
    chk("start_busy", busy, 1);
    chk("start_cnt", beat_cnt, 0);
    for (int i = 0; i < 7; i++) do_beat(32'h1000_0000 + i);
    chk("pre_last_valid", line_valid, 0);
    chk("pre_last_cnt", beat_cnt, 7);
    do_beat(32'h1000_0007);
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'h1000_0000 + i;
    chk("basic_valid", line_valid, 1);
    chk("basic_line", line_data, exp_line);
    chk("basic_word", word_data, 32'h1000_0005);
    chk("basic_cnt", beat_cnt, 8);
    chk("basic_busy", busy, 1);

    // Back-pressure
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", line_valid, 1);
      chk("bp_line", line_data, exp_line);
    end
    accept();
    chk("acc_valid", line_valid, 0);
    chk("acc_busy", busy, 0);
    chk("acc_cnt", beat_cnt, 0);
    chk("acc_line_kept", line_data, exp_line);

    // Gapped beats with rd_en-less strobes in the gap
    do_start(3'd2);
    for (int i = 0; i < 4; i++) do_beat(32'h2000_0000 + i);
    for (int i = 0; i < 5; i++) begin
      edge_flag = (i == 1 || i == 3); rd_en = 1'b0; memload = 32'hDEAD_BEEF;
      tick();
    end
    edge_flag = 1'b0;
    chk("gap_cnt", beat_cnt, 4);
    chk("gap_valid", line_valid, 0);
    for (int i = 4; i < 8; i++) do_beat(32'h2000_0000 + i);
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'h2000_0000 + i;
    chk("gap_line_valid", line_valid, 1);
    chk("gap_line", line_data, exp_line);
    chk("gap_word", word_data, 32'h2000_0002);
    accept();

    // Overrun and extra beat
    do_start(3'd1);
    for (int i = 0; i < 3; i++) do_beat(32'h3000_0000 + i);
    start = 1'b1; col_choice = 3'd7;
    do_beat(32'h3000_0003);
    start = 1'b0;
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_busy", busy, 1);
    for (int i = 4; i < 8; i++) do_beat(32'h3000_0000 + i);
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'h3000_0000 + i;
    chk("ovr_valid", line_valid, 1);
    chk("ovr_line", line_data, exp_line);
    chk("ovr_word", word_data, 32'h3000_0001);
    chk("ovr_extra_before", err_extra, 0);
    do_beat(32'h0BAD_0BAD);
    chk("extra_flag", err_extra, 1);
    chk("extra_line", line_data, exp_line);
    chk("extra_cnt", beat_cnt, 8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_errs", {err_overrun, err_extra, err_timeout}, 0);
    chk("clr_busy", busy, 0);
    chk("clr_valid", line_valid, 0);
    chk("clr_line_kept", line_data, exp_line);

    // Start coinciding with accept is legal
    do_start(3'd3);
    for (int i = 0; i < 8; i++) do_beat(32'h4000_0000 + i);
    chk("chain_valid", line_valid, 1);
    chk("chain_word", word_data, 32'h4000_0003);
    start = 1'b1; col_choice = 3'd6;
    accept();
    start = 1'b0;
    chk("chain_busy", busy, 1);
    chk("chain_valid_lo", line_valid, 0);
    chk("chain_no_ovr", err_overrun, 0);
    chk("chain_cnt", beat_cnt, 0);

    // Abort after 3 beats; start alongside clear is ignored
    for (int i = 0; i < 3; i++) do_beat(32'h5000_0000 + i);
    chk("abort_pre_cnt", beat_cnt, 3);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", beat_cnt, 0);
    chk("abort_valid", line_valid, 0);
    tick();
    chk("abort_start_ignored", busy, 0);

    // Async reset mid-capture
    do_start(3'd4);
    do_beat(32'h6000_0000);
    do_beat(32'h6000_0001);
    #2 nRST = 1'b0;
    #1;
    chk("arst_line", line_data, '0);
    chk("arst_word", word_data, '0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", beat_cnt, 0);
    chk("arst_valid", line_valid, 0);
    @(negedge CLKx2);
    nRST = 1'b1;
    tick();

    // Stalled burst: 4 beats then silence
    do_start(3'd0);
    for (int i = 0; i < 4; i++) do_beat(32'h7000_0000 + i);
    for (int i = 0; i < 27; i++) tick();
    chk("tmo_pre_flag", err_timeout, 0);
    chk("tmo_pre_busy", busy, 1);
    tick();
`ifdef RD_BURST_TIMEOUT_EN
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_cnt", beat_cnt, 0);
`else
    chk("tmo_flag", err_timeout, 0);
    chk("tmo_busy", busy, 1);
    chk("tmo_cnt", beat_cnt, 4);
`endif
    chk("tmo_valid", line_valid, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("tmo_valid_late", line_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
